karatsuba_gf2_seq_mul: RTL and testbench

//  Parametrised sequential two-way Karatsuba multiplier over GF(2)[x] (carry-less, XOR accumulate).

---
 rtl/karatsuba_gf2_seq_mul.sv | 144 ++++++++++++++
 tb/tb_karatsuba_gf2_seq_mul.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_gf2_seq_mul.sv
// Sequential two-way Karatsuba carry-less multiplier over GF(2)[x].
// Each operand is split into high/low halves. Three half-size products (high, low, mid)
// run in parallel, each consuming D multiplier bits per cycle with shift-and-XOR.
// One final cycle recombines the three products into the full result.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      request, sampled only while idle
//   a, b       N-bit operands, latched on the accepting edge
//   busy       high from the accepting edge until done
//   done       one-cycle pulse when c holds a new product
//   c          2N-bit carry-less product a*b
module karatsuba_gf2_seq_mul #(
  parameter int unsigned N = 521,
  parameter int unsigned D = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] c
);

  localparam int unsigned LO   = N / 2;
  localparam int unsigned HI   = N - LO;
  localparam int unsigned K    = (HI + D - 1) / D;
  localparam int unsigned PW   = 2 * HI - 1;
  localparam int unsigned CW   = $clog2(K + 1);
  localparam int unsigned CWID = 2 * N;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_COMB} state_t;

  state_t          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [CWID-1:0] c_q, c_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // Multiplicands shift left by D per cycle; multipliers shift right by D per cycle.
  logic [PW-1:0]   ah_q, ah_d, al_q, al_d, am_q, am_d;
  logic [HI-1:0]   bh_q, bh_d, bl_q, bl_d, bm_q, bm_d;
  logic [PW-1:0]   ph_q, ph_d, pl_q, pl_d, pm_q, pm_d;

  assign busy = busy_q;
  assign done = done_q;
  assign c    = c_q;

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    c_d     = c_q;
    cnt_d   = cnt_q;
    ah_d    = ah_q;
    al_d    = al_q;
    am_d    = am_q;
    bh_d    = bh_q;
    bl_d    = bl_q;
    bm_d    = bm_q;
    ph_d    = ph_q;
    pl_d    = pl_q;
    pm_d    = pm_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // The low halves are zero-extended, so their bits at or above LO contribute nothing.
          ah_d    = PW'(a[N-1:LO]);
          al_d    = PW'(a[LO-1:0]);
          am_d    = PW'(a[N-1:LO] ^ HI'(a[LO-1:0]));
          bh_d    = b[N-1:LO];
          bl_d    = HI'(b[LO-1:0]);
          bm_d    = b[N-1:LO] ^ HI'(b[LO-1:0]);
          ph_d    = '0;
          pl_d    = '0;
          pm_d    = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        // Multiplier bits past HI have been shifted in as zeros, which masks a short final step.
        for (int j = 0; j < int'(D); j++) begin
          if (bh_q[j]) ph_d = ph_d ^ (ah_q << j);
          if (bl_q[j]) pl_d = pl_d ^ (al_q << j);
          if (bm_q[j]) pm_d = pm_d ^ (am_q << j);
        end
        ah_d  = ah_q << D;
        al_d  = al_q << D;
        am_d  = am_q << D;
        bh_d  = bh_q >> D;
        bl_d  = bl_q >> D;
        bm_d  = bm_q >> D;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(K - 1)) state_d = S_COMB;
      end
      S_COMB: begin
        c_d     = (CWID'(ph_q) << (2 * LO)) ^ (CWID'(pm_q ^ ph_q ^ pl_q) << LO) ^ CWID'(pl_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_q     <= '0;
      cnt_q   <= '0;
      ah_q    <= '0;
      al_q    <= '0;
      am_q    <= '0;
      bh_q    <= '0;
      bl_q    <= '0;
      bm_q    <= '0;
      ph_q    <= '0;
      pl_q    <= '0;
      pm_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      ah_q    <= ah_d;
      al_q    <= al_d;
      am_q    <= am_d;
      bh_q    <= bh_d;
      bl_q    <= bl_d;
      bm_q    <= bm_d;
      ph_q    <= ph_d;
      pl_q    <= pl_d;
      pm_q    <= pm_d;
    end
  end

endmodule

// File: tb/tb_karatsuba_gf2_seq_mul.sv
// Bench for karatsuba_gf2_seq_mul: three N=521 instances (D=1,4,7) and one N=8,D=3 instance,
// checked against a plain bit-by-bit carry-less reference product.
module tb_karatsuba_gf2_seq_mul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [520:0]   a, b;
  logic           start_v [3];
  logic           busy_v  [3];
  logic           done_v  [3];
  logic [1041:0]  c_v     [3];
  logic           start8, busy8, done8;
  logic [7:0]     a8, b8;
  logic [15:0]    c8;

  int ntests = 0;
  int nfail  = 0;

  karatsuba_gf2_seq_mul #(.N(521), .D(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a), .b(b),
    .busy(busy_v[0]), .done(done_v[0]), .c(c_v[0]));
  karatsuba_gf2_seq_mul #(.N(521), .D(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a), .b(b),
    .busy(busy_v[1]), .done(done_v[1]), .c(c_v[1]));
  karatsuba_gf2_seq_mul #(.N(521), .D(7)) u_d7 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a), .b(b),
    .busy(busy_v[2]), .done(done_v[2]), .c(c_v[2]));
  karatsuba_gf2_seq_mul #(.N(8), .D(3)) u_n8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .c(c8));

  // Reference: schoolbook carry-less product.
  function automatic logic [1041:0] clmul(input logic [520:0] x, input logic [520:0] y);
    logic [1041:0] r;
    r = '0;
    for (int i = 0; i < 521; i++)
      if (y[i]) r = r ^ (1042'(x) << i);
    return r;
  endfunction

  function automatic logic [15:0] clmul8(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (y[i]) r = r ^ (16'(x) << i);
    return r;
  endfunction

  function automatic logic [520:0] rnd();
    logic [520:0] r;
    r = '0;
    for (int i = 0; i < 17; i++) r = (r << 32) ^ 521'($urandom);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [1041:0] obs, input logic [1041:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed(low128)=%0h expected(low128)=%0h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  // Run one op on a 521-bit instance; check latency, busy length and product.
  task automatic do_op(input int idx, input logic [520:0] x, input logic [520:0] y,
                       input int k, input string tag);
    logic [1041:0] exp;
    int lat, bcnt;
    bit seen;
    exp = clmul(x, y);
    @(negedge clk);
    a = x; b = y; start_v[idx] = 1'b1;
    @(posedge clk); #1;
    start_v[idx] = 1'b0;
    a = rnd(); b = rnd();
    lat = 0; bcnt = 0; seen = 1'b0;
    while (!seen && lat < k + 20) begin
      if (busy_v[idx]) bcnt++;
      @(posedge clk); #1;
      lat++;
      seen = done_v[idx];
    end
    chk({tag, "_lat"}, 1042'(lat), 1042'(k + 1));
    chk({tag, "_busy"}, 1042'(bcnt), 1042'(k + 1));
    chk({tag, "_c"}, c_v[idx], exp);
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      seen = done8;
    end
    chk({tag, "_lat"}, 1042'(lat), 1042'(3));
    chk({tag, "_c"}, 1042'(c8), 1042'(clmul8(x, y)));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [520:0] x1, y1, x2, y2, one, top;
    int lat;
    bit seen;
    rst = 1'b1;
    start8 = 1'b0;
    a = '0; b = '0; a8 = '0; b8 = '0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 1042'(busy_v[0]), 1042'(0));
    chk("rst_done", 1042'(done_v[0]), 1042'(0));
    chk("rst_c", c_v[0], '0);
    chk("rst_c8", 1042'(c8), 1042'(0));
    @(negedge clk);
    rst = 1'b0;

    // Directed corner products.
    one = 521'(1);
    top = one << 520;
    do_op(0, one, one, 261, "one");
    do_op(0, top, top, 261, "top");
    chk("top_bit1040", 1042'(c_v[0][1040]), 1042'(1));
    do_op(0, 521'(3), 521'(3), 261, "three");
    chk("three_is5", c_v[0], 1042'(5));
    do_op(0, '0, rnd(), 261, "zero");
    do_op(0, '1, '1, 261, "ones");

    // Random pairs on each D.
    for (int n = 0; n < 8; n++) do_op(0, rnd(), rnd(), 261, "rand_d1");
    for (int n = 0; n < 25; n++) do_op(1, rnd(), rnd(), 66, "rand_d4");
    for (int n = 0; n < 25; n++) do_op(2, rnd(), rnd(), 38, "rand_d7");
    do_op(2, top, '1, 38, "top_d7");

    // Small instance.
    op8(8'hFF, 8'hFF, "ff_ff");
    chk("ff_ff_5555", 1042'(c8), 1042'(16'h5555));
    op8(8'h80, 8'h80, "msb_sq");
    op8(8'h0F, 8'hF0, "halves");
    for (int n = 0; n < 400; n++) op8(8'($urandom), 8'($urandom), "rand_n8");

    // Start held high: second op accepted on the done cycle, mid-op start ignored.
    x1 = rnd(); y1 = rnd(); x2 = rnd(); y2 = rnd();
    @(negedge clk);
    a = x1; b = y1; start_v[0] = 1'b1;
    @(posedge clk); #1;
    a = x2; b = y2;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      seen = done_v[0];
    end
    chk("hold_lat1", 1042'(lat), 1042'(262));
    chk("hold_c1", c_v[0], clmul(x1, y1));
    chk("hold_busy_at_done", 1042'(busy_v[0]), 1042'(0));
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    chk("hold_accept2", 1042'(busy_v[0]), 1042'(1));
    chk("hold_c_kept", c_v[0], clmul(x1, y1));
    a = rnd(); b = rnd();
    lat = 0; seen = 1'b0;
    while (!seen && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      seen = done_v[0];
    end
    chk("hold_lat2", 1042'(lat), 1042'(262));
    chk("hold_c2", c_v[0], clmul(x2, y2));

    // Single start pulse mid-MUL is ignored.
    x1 = rnd(); y1 = rnd();
    @(negedge clk);
    a = x1; b = y1; start_v[2] = 1'b1;
    @(posedge clk); #1;
    start_v[2] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    a = rnd(); b = rnd(); start_v[2] = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0;
    lat = 11; seen = 1'b0;
    while (!seen && lat < 80) begin
      @(posedge clk); #1;
      lat++;
      seen = done_v[2];
    end
    chk("pulse_lat", 1042'(lat), 1042'(39));
    chk("pulse_c", c_v[2], clmul(x1, y1));

    // Reset in the middle of MUL aborts the operation.
    @(negedge clk);
    a = rnd(); b = rnd(); start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (99) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 1042'(busy_v[0]), 1042'(0));
    chk("midrst_done", 1042'(done_v[0]), 1042'(0));
    chk("midrst_c", c_v[0], '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (300) begin
      @(posedge clk); #1;
      if (done_v[0]) chk("midrst_no_done", 1042'(done_v[0]), 1042'(0));
    end
    do_op(0, rnd(), rnd(), 261, "after_rst");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
